// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the double-dabble BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int DIGIT_WIDTH = 4;

  localparam logic [DIGIT_WIDTH-1:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [DIGIT_WIDTH-1:0] ADJ_OFFSET    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - per-digit add-3 correction applied before each double-dabble shift
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_WIDTH-1:0] i_digit,
  output logic [DIGIT_WIDTH-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADJ_THRESHOLD) begin
      o_digit = i_digit + ADJ_OFFSET;
    end
  end

endmodule

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential binary-to-BCD converter (shift-and-add-3), fixed BITS-cycle conversion
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int DIGITS = 3
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [BITS-1:0]               i_binary,
  output logic                          o_busy,
  output logic                          o_finished,
  output logic [DIGIT_WIDTH*DIGITS-1:0] o_bcd
);

  localparam int BCD_W = DIGIT_WIDTH * DIGITS;
  localparam int CNT_W = $clog2(BITS + 1);

  localparam longint unsigned MAX_BIN   = (64'd1 << BITS) - 64'd1;
  localparam longint unsigned BCD_RANGE = 64'd10 ** DIGITS;

  generate
    if (BCD_RANGE <= MAX_BIN) begin : g_range_check
      $error("bcd_converter: DIGITS too small to represent every BITS-wide input");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [BITS-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               finished_q, finished_d;
  logic [BCD_W-1:0]   work_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .i_digit (work_q[g*DIGIT_WIDTH +: DIGIT_WIDTH]),
      .o_digit (work_adj[g*DIGIT_WIDTH +: DIGIT_WIDTH])
    );
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    finished_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          shift_d = i_binary;
          work_d  = '0;
          cnt_d   = CNT_W'(BITS);
          busy_d  = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // Adjust all digits first, then shift the whole {BCD, binary} chain left by one.
        {work_d, shift_d} = {work_adj[BCD_W-2:0], shift_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d      = work_q;
        finished_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_finished = finished_q;
  assign o_bcd      = bcd_q;

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 Parameter BITS, default 8, SHALL set the binary input width (sized for a 4-bit multiplier's 8-bit product).
REQ-002 Parameter DIGITS, default 3, SHALL set the number of 4-bit BCD output digits.
REQ-003 Port i_clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port i_reset  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 Port i_start  input  1  SHALL be the request strobe, sampled only in IDLE.
REQ-006 Port i_binary  input  BITS  SHALL be the unsigned value to convert, captured when a request is accepted.
REQ-007 Port o_busy  output  1  SHALL be high while in CONVERT or DONE.
REQ-008 Port o_finished  output  1  SHALL pulse high for exactly one cycle in DONE.
REQ-009 Port o_bcd  output  4*DIGITS  SHALL hold the packed BCD result, least significant digit in bits [3:0].

Function
REQ-010 States SHALL be IDLE, CONVERT and DONE, using the shift-and-add-3 (double-dabble) algorithm.
REQ-011 In IDLE with i_start=1: capture i_binary into the shift register, clear the BCD working register, load bit counter = BITS, go to CONVERT.
REQ-012 In IDLE with i_start=0: stay in IDLE and hold o_bcd unchanged.
REQ-013 Each CONVERT cycle: every working digit >= 5 SHALL get +3, then the concatenated {BCD, shift register} SHALL shift left by one, and the counter SHALL decrement.
REQ-014 When the counter reaches 0 after the final shift, go to DONE; CONVERT SHALL last exactly BITS cycles, with no early exit for zero or small inputs.
REQ-015 In DONE: o_bcd SHALL be updated from the working register, o_finished=1, then IDLE on the next edge.
REQ-016 Latency: with i_start accepted on edge N, o_finished SHALL be high during the cycle after edge N+BITS+1; o_bcd SHALL be valid from that point until the next accepted request completes.
REQ-017 i_start and i_binary SHALL be ignored outside IDLE; input changes mid-conversion do not affect the result.
REQ-018 If i_start is held high continuously, a new conversion SHALL start in the IDLE cycle after each DONE (BITS+2 cycles per result).
REQ-019 Elaboration SHALL fail if 10^DIGITS <= 2^BITS - 1.
REQ-020 The bit counter width SHALL be $clog2(BITS+1); digit adjust comparisons SHALL be 4-bit unsigned.

Reset
REQ-021 Asserting i_reset (low) SHALL immediately force state=IDLE, o_busy=0, o_finished=0, o_bcd=0, and zero the counter, shift and working registers.
REQ-022 A reset during CONVERT SHALL abort the conversion with no o_finished pulse; the first i_start after release SHALL begin a fresh conversion.

Structure
REQ-023 Package bcd_pkg SHALL hold the state enum, DIGIT_WIDTH=4, and the adjust threshold/offset constants (5, 3).
REQ-024 Sub-module bcd_digit_adjust (combinational, 4-bit in/out, +3 if >=5) SHALL be instantiated DIGITS times.

Verification
REQ-025 Drive i_binary=0 and pulse i_start -> after BITS+1 cycles o_finished=1 and o_bcd=12'h000.
REQ-026 Drive i_binary=255 -> o_bcd=12'h255; i_binary=99 -> 12'h099; i_binary=200 -> 12'h200, each with o_finished exactly one cycle wide.
REQ-027 Change i_binary from 37 to 142 and pulse i_start mid-CONVERT -> result still 12'h037, and no second conversion starts.
REQ-028 Assert reset at CONVERT cycle 4 -> outputs 0 immediately and no o_finished; then convert 128 -> 12'h128.
REQ-029 Hold i_start high and sweep i_binary 0..255 once per BITS+2 cycles -> every result equals its decimal value and o_busy drops for one cycle between conversions.
REQ-030 Chain after Multiplier with BITS=4: convert every x*y for x,y in 0..15 -> BCD equals the decimal product (e.g. 15*15 -> 12'h225).
